// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter.
//   arb_state_t : arbitration FSM state (IDLE, OWN0, OWN1)
//   req_id_t    : requester identifier stored in the read-return ID FIFO
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam int REQ_ID_W = $bits(req_id_t);

    // Lock state that holds the grant on a given requester
    function automatic arb_state_t own_state(input req_id_t id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/sdram_arbiter_id_fifo.sv
// id_fifo: small FIFO of requester IDs for outstanding reads.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push/push_data : enqueue an ID (caller never pushes while full unless popping)
//   pop        : dequeue request; ignored when empty unless a push lands the same cycle
//   head       : current head entry, bypassed from push_data when empty
//   full/empty : occupancy flags
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // An empty FIFO can still pop when the entry arrives in the same cycle;
    // head then comes straight from the write port.
    assign pop_eff = pop && (!empty || push);
    assign head    = empty ? push_data : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-requester round-robin arbiter onto one Avalon-MM SDRAM port.
//   clk, rst                  : clock, synchronous active-high reset
//   rN_address/read/write/writedata : requester N command (N = 0,1)
//   rN_waitrequest            : requester N stall
//   rN_readdata/readdatavalid : requester N read return, routed by ID FIFO
//   master_*                  : shared SDRAM command / response
//   err_unexpected            : sticky, read data returned with nothing pending
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_waitrequest,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_readdatavalid,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_waitrequest,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_readdatavalid,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_waitrequest,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              err_unexpected
);

    arb_state_t state_q, state_d;
    req_id_t    last_grant_q, last_grant_d;
    logic       err_q, err_d;

    logic       active0, active1;
    logic       grant_valid;
    req_id_t    grant_id;
    logic       sel_read, sel_write;
    logic       fifo_stall, accept, push, rdv_ok;
    logic       fifo_full, fifo_empty;
    req_id_t    fifo_head;

    assign active0 = r0_read || r0_write;
    assign active1 = r1_read || r1_write;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state_q)
            OWN0: begin
                grant_valid = active0;
                grant_id    = 1'b0;
            end
            OWN1: begin
                grant_valid = active1;
                grant_id    = 1'b1;
            end
            default: begin
                if (active0 && active1) begin
                    grant_valid = 1'b1;
                    grant_id    = ~last_grant_q;
                end else if (active0) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (active1) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
            end
        endcase
        // Reset suppresses every grant, which silences the master port
        // and stalls both requesters.
        if (rst) begin
            grant_valid = 1'b0;
        end

        // Read wins over write when a requester illegally asserts both.
        sel_read   = grant_id ? r1_read : r0_read;
        sel_write  = (grant_id ? r1_write : r0_write) && !sel_read;
        fifo_stall = grant_valid && sel_read && fifo_full;
        accept     = grant_valid && !master_waitrequest && !fifo_stall;
        push       = accept && sel_read;

        state_d      = IDLE;
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant_id;
        end else if (grant_valid) begin
            state_d = own_state(grant_id);
        end

        // A return is only meaningful if an ID is queued or arriving now.
        rdv_ok = master_readdatavalid && !rst && (!fifo_empty || push);
        err_d  = err_q || (master_readdatavalid && fifo_empty && !push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    id_fifo #(
        .DEPTH (OUTST),
        .WIDTH (REQ_ID_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (grant_id),
        .pop       (rdv_ok),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign master_address   = grant_id ? r1_address   : r0_address;
    assign master_writedata = grant_id ? r1_writedata : r0_writedata;
    assign master_read      = grant_valid && sel_read && !fifo_full;
    assign master_write     = grant_valid && sel_write;

    assign r0_waitrequest = !(grant_valid && (grant_id == 1'b0)) || master_waitrequest || fifo_stall;
    assign r1_waitrequest = !(grant_valid && (grant_id == 1'b1)) || master_waitrequest || fifo_stall;

    assign r0_readdata      = master_readdata;
    assign r1_readdata      = master_readdata;
    assign r0_readdatavalid = rdv_ok && (fifo_head == 1'b0);
    assign r1_readdatavalid = rdv_ok && (fifo_head == 1'b1);

    assign err_unexpected = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OUTST  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] r0_address, r1_address, master_address;
    logic              r0_read, r0_write, r1_read, r1_write;
    logic [DATA_W-1:0] r0_writedata, r1_writedata, master_writedata;
    logic              r0_waitrequest, r1_waitrequest;
    logic [DATA_W-1:0] r0_readdata, r1_readdata, master_readdata;
    logic              r0_readdatavalid, r1_readdatavalid;
    logic              master_read, master_write;
    logic              master_waitrequest, master_readdatavalid;
    logic              err_unexpected;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .OUTST  (OUTST)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .r0_address           (r0_address),
        .r0_read              (r0_read),
        .r0_write             (r0_write),
        .r0_writedata         (r0_writedata),
        .r0_waitrequest       (r0_waitrequest),
        .r0_readdata          (r0_readdata),
        .r0_readdatavalid     (r0_readdatavalid),
        .r1_address           (r1_address),
        .r1_read              (r1_read),
        .r1_write             (r1_write),
        .r1_writedata         (r1_writedata),
        .r1_waitrequest       (r1_waitrequest),
        .r1_readdata          (r1_readdata),
        .r1_readdatavalid     (r1_readdatavalid),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .err_unexpected       (err_unexpected)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are applied right after an edge; outputs settle after #1.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        r0_address = '0; r0_read = 0; r0_write = 0; r0_writedata = '0;
        r1_address = '0; r1_read = 0; r1_write = 0; r1_writedata = '0;
        master_waitrequest = 0; master_readdata = '0; master_readdatavalid = 0;
        tick();
        tick();

        // Outputs forced quiet while reset is held
        r0_read = 1; r1_write = 1; master_readdatavalid = 1;
        settle();
        chk("rst_master_read", master_read, 0);
        chk("rst_master_write", master_write, 0);
        chk("rst_r0_wait", r0_waitrequest, 1);
        chk("rst_r1_wait", r1_waitrequest, 1);
        chk("rst_r0_rdv", r0_readdatavalid, 0);
        chk("rst_r1_rdv", r1_readdatavalid, 0);
        chk("rst_err", err_unexpected, 0);
        $display("[TB] reset: outputs checked");
        r0_read = 0; r1_write = 0; master_readdatavalid = 0;
        tick();
        rst = 1'b0;

        // Single read, zero-latency grant, return 3 cycles later
        r0_read = 1; r0_address = 32'h100;
        settle();
        chk("rd_master_read", master_read, 1);
        chk("rd_master_addr", master_address, 32'h100);
        chk("rd_r0_wait", r0_waitrequest, 0);
        tick();
        r0_read = 0;
        tick();
        tick();
        master_readdatavalid = 1; master_readdata = 32'hDEADBEEF;
        settle();
        chk("rd_r0_rdv", r0_readdatavalid, 1);
        chk("rd_r1_rdv", r1_readdatavalid, 0);
        chk("rd_r0_data", r0_readdata, 32'hDEADBEEF);
        tick();
        master_readdatavalid = 0;
        settle();
        chk("rd_err", err_unexpected, 0);
        $display("[TB] read 0x100 -> 0xDEADBEEF routed to r0");

        // Contending writes alternate, r0 first after reset
        do_reset();
        r0_write = 1; r0_address = 32'hA0; r0_writedata = 32'h1111;
        r1_write = 1; r1_address = 32'hB0; r1_writedata = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("wr_master_write", master_write, 1);
            chk("wr_master_addr", master_address, (i % 2 == 0) ? 32'hA0 : 32'hB0);
            chk("wr_master_data", master_writedata, (i % 2 == 0) ? 32'h1111 : 32'h2222);
            chk("wr_r0_wait", r0_waitrequest, (i % 2 == 0) ? 0 : 1);
            chk("wr_r1_wait", r1_waitrequest, (i % 2 == 0) ? 1 : 0);
            $display("[TB] write cycle %0d granted r%0d", i, i % 2);
            tick();
        end
        r0_write = 0; r1_write = 0;

        // r1 read held by waitrequest for 5 cycles, r0 locked out
        master_waitrequest = 1;
        r1_read = 1; r1_address = 32'h200;
        settle();
        chk("hold_addr0", master_address, 32'h200);
        chk("hold_r1_wait0", r1_waitrequest, 1);
        tick();
        r0_write = 1; r0_address = 32'h300;
        for (int i = 1; i < 5; i++) begin
            settle();
            chk("hold_addr", master_address, 32'h200);
            chk("hold_read", master_read, 1);
            chk("hold_r0_wait", r0_waitrequest, 1);
            tick();
        end
        master_waitrequest = 0;
        settle();
        chk("hold_accept_addr", master_address, 32'h200);
        chk("hold_r1_wait", r1_waitrequest, 0);
        chk("hold_r0_wait_acc", r0_waitrequest, 1);
        tick();
        r1_read = 0;
        settle();
        chk("after_r0_write", master_write, 1);
        chk("after_r0_addr", master_address, 32'h300);
        chk("after_r0_wait", r0_waitrequest, 0);
        tick();
        r0_write = 0;
        master_readdatavalid = 1; master_readdata = 32'h5555;
        settle();
        chk("hold_ret_r1", r1_readdatavalid, 1);
        chk("hold_ret_r0", r0_readdatavalid, 0);
        tick();
        master_readdatavalid = 0;
        $display("[TB] locked grant held r1 for 5 cycles, r0 served after");

        // Fill the ID FIFO with r0,r1,r1,r0; fifth read must stall
        for (int i = 0; i < 4; i++) begin
            if (i == 0 || i == 3) begin r0_read = 1; r0_address = 32'h10 + i; end
            else begin r1_read = 1; r1_address = 32'h10 + i; end
            settle();
            chk("fill_read", master_read, 1);
            tick();
            r0_read = 0; r1_read = 0;
        end
        r0_read = 1; r0_address = 32'h14;
        settle();
        chk("full_master_read", master_read, 0);
        chk("full_r0_wait", r0_waitrequest, 1);
        tick();
        settle();
        chk("full_master_read2", master_read, 0);
        master_readdatavalid = 1; master_readdata = 32'h1;
        settle();
        chk("ret0_r0", r0_readdatavalid, 1);
        chk("ret0_r1", r1_readdatavalid, 0);
        chk("ret0_still_full", master_read, 0);
        tick();
        master_readdata = 32'h2;
        settle();
        chk("ret1_r1", r1_readdatavalid, 1);
        chk("ret1_r0", r0_readdatavalid, 0);
        chk("fifth_issue", master_read, 1);
        chk("fifth_addr", master_address, 32'h14);
        tick();
        r0_read = 0;
        master_readdata = 32'h3;
        settle();
        chk("ret2_r1", r1_readdatavalid, 1);
        tick();
        master_readdata = 32'h4;
        settle();
        chk("ret3_r0", r0_readdatavalid, 1);
        chk("ret3_r1", r1_readdatavalid, 0);
        tick();
        master_readdata = 32'h5;
        settle();
        chk("ret4_fifth_r0", r0_readdatavalid, 1);
        tick();
        master_readdatavalid = 0;
        settle();
        chk("fill_err", err_unexpected, 0);
        $display("[TB] full FIFO stalled fifth read, returns routed 0,1,1,0,0");

        // Unexpected return with empty FIFO
        master_readdatavalid = 1;
        settle();
        chk("unexp_r0", r0_readdatavalid, 0);
        chk("unexp_r1", r1_readdatavalid, 0);
        tick();
        master_readdatavalid = 0;
        settle();
        chk("unexp_err", err_unexpected, 1);
        tick();
        chk("unexp_err_sticky", err_unexpected, 1);
        do_reset();
        chk("unexp_err_cleared", err_unexpected, 0);
        $display("[TB] unexpected return flagged, cleared by reset");

        // Reset with two reads in flight
        r0_read = 1; r0_address = 32'h40;
        tick();
        r0_read = 0; r1_read = 1; r1_address = 32'h41;
        settle();
        chk("inflight_r1_read", master_read, 1);
        tick();
        rst = 1; r1_read = 0; r0_read = 1; master_readdatavalid = 1;
        settle();
        chk("midrst_read", master_read, 0);
        chk("midrst_r0_wait", r0_waitrequest, 1);
        chk("midrst_r1_wait", r1_waitrequest, 1);
        chk("midrst_r0_rdv", r0_readdatavalid, 0);
        tick();
        rst = 0; r0_read = 0;
        settle();
        chk("postrst_r0_rdv", r0_readdatavalid, 0);
        chk("postrst_r1_rdv", r1_readdatavalid, 0);
        tick();
        master_readdatavalid = 0;
        settle();
        chk("postrst_err", err_unexpected, 1);
        $display("[TB] reset discarded in-flight reads, late returns flagged");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter OUTST, default 4, max in-flight reads (power of 2, >=2).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rN_address/rN_read/rN_write/rN_writedata  in  ADDR_W/1/1/DATA_W  requester N command, N in {0,1}.
REQ-007 rN_waitrequest  out  1  requester N stall.
REQ-008 rN_readdata/rN_readdatavalid  out  DATA_W/1  requester N read return.
REQ-009 master_address/master_read/master_write/master_writedata  out  ADDR_W/1/1/DATA_W  shared SDRAM command.
REQ-010 master_waitrequest/master_readdata/master_readdatavalid  in  1/DATA_W/1  shared SDRAM response.
REQ-011 err_unexpected  out  1  sticky: readdatavalid with no read pending.

Function
REQ-012 Requester N is "active" when rN_read|rN_write; rN_read&rN_write together is illegal; the arbiter treats it as a read.
REQ-013 FSM states IDLE, OWN0, OWN1; reset state IDLE.
REQ-014 IDLE/arbitration: one active -> grant it; both active -> grant the one not in last_grant (round-robin); none -> stay IDLE.
REQ-015 Grant is combinational in the same cycle as arbitration; the granted command drives master_* that cycle (zero-cycle arbitration latency).
REQ-016 Once granted with master_waitrequest=1, FSM enters OWNn; grant is locked to n until the command is accepted (Avalon hold rule).
REQ-017 Accept = granted active & master_waitrequest=0; on accept last_grant<=n and FSM returns to IDLE-equivalent arbitration next cycle.
REQ-018 Back-to-back: a requester accepted in cycle t cannot be granted in t+1 if the other is active (strict alternation under contention).
REQ-019 rN_waitrequest = !(granted to N) | master_waitrequest | (read & ID FIFO full); the non-granted active requester always sees 1.
REQ-020 master_read/master_write are 0 when no grant; master_address/master_writedata are don't-care then but driven from requester 0.
REQ-021 Read issue with ID FIFO full: master_read forced 0, requester stalled, grant held.
REQ-022 ID FIFO (depth OUTST, 1-bit entries): push requester ID on read accept; pop on master_readdatavalid.
REQ-023 Simultaneous push and pop when full or empty: both take effect; count unchanged except empty+pop (see REQ-025).
REQ-024 master_readdata fans out to both rN_readdata; rN_readdatavalid = master_readdatavalid & (FIFO head == N), combinational.
REQ-025 master_readdatavalid with FIFO empty and no same-cycle push: no rN_readdatavalid, no pop, err_unexpected<=1.
REQ-026 Writes are posted: no FIFO entry, no response.
REQ-027 Read pointers wrap modulo OUTST; count width clog2(OUTST)+1.

Reset
REQ-028 rst=1 at a clock edge: FSM<=IDLE, last_grant<=1 (requester 0 wins first tie), FIFO count/pointers<=0, err_unexpected<=0.
REQ-029 During rst all master_read/master_write=0, rN_waitrequest=1, rN_readdatavalid=0.
REQ-030 Reset mid-transaction discards in-flight IDs; later readdatavalid for them sets err_unexpected.

Structure
REQ-031 Shared package sdram_arb_pkg holds arb state enum (IDLE, OWN0, OWN1) and requester-ID type.
REQ-032 ID FIFO is sub-module id_fifo (parameter DEPTH, WIDTH); arbiter and routing stay in sdram_arbiter.

Verification
REQ-033 r0 read addr 0x100, waitrequest=0 -> master_read=1, address 0x100 same cycle; data 0xDEADBEEF returned 3 cycles later -> r0_readdatavalid=1, r1_readdatavalid=0.
REQ-034 r0,r1 both write every cycle, waitrequest=0 -> grants alternate 0,1,0,1; first grant r0 after reset.
REQ-035 r1 read granted, master_waitrequest=1 for 5 cycles while r0 asserts -> master_address stays r1's value, r0_waitrequest=1 throughout; r0 granted after r1 accepted.
REQ-036 Four reads r0,r1,r1,r0 with no return, fifth read r0 -> fifth stalled (master_read=0); returns routed 0,1,1,0; fifth then issues.
REQ-037 master_readdatavalid pulsed with FIFO empty -> no requester valid, err_unexpected=1 until rst.
REQ-038 rst asserted with 2 reads in flight -> returns set err_unexpected; outputs match REQ-029 during reset.
